// File: rtl/gbox_align_pkg.sv
// Shared state encoding and constants for the gearbox RX word aligner.
package gbox_align_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4,
    ERROR  = 3'd5
  } align_state_t;

  localparam logic [9:0] GBOX_ALIGN_DEF_PATTERN = 10'h3F8;
  localparam int         GBOX_ALIGN_SLIP_CW     = 4;

endpackage

// File: rtl/gbox_rx_word_align.sv
// Fabric-side word aligner: issues gearbox bitslip pulses until the training
// word is seen repeatedly, then reports lock and forwards aligned data.
module gbox_rx_word_align
  import gbox_align_pkg::*;
#(
  parameter int PAR_DWID      = 10,
  parameter int PAR_MATCH_CNT = 4,
  parameter int PAR_LOSS_CNT  = 4,
  parameter int PAR_SLIP_WAIT = 4
) (
  input  logic                          core_clk,
  input  logic                          rx_reset,
  input  logic                          cfg_en,
  input  logic [PAR_DWID-1:0]           cfg_pattern,
  input  logic                          train_start,
  input  logic                          rx_dvalid,
  input  logic [PAR_DWID-1:0]           rx_data,
  output logic                          bitslip_adj,
  output logic                          align_lock,
  output logic                          align_error,
  output logic [GBOX_ALIGN_SLIP_CW-1:0] slip_cnt,
  output logic [PAR_DWID-1:0]           dout,
  output logic                          dout_valid,
  output align_state_t                  state_dbg
);

  localparam int MW = $clog2(PAR_MATCH_CNT + 1);
  localparam int LW = $clog2(PAR_LOSS_CNT + 1);
  localparam int WW = $clog2(PAR_SLIP_WAIT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(PAR_MATCH_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(PAR_LOSS_CNT - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(PAR_SLIP_WAIT - 1);
  localparam logic [GBOX_ALIGN_SLIP_CW-1:0] SLIP_FULL = GBOX_ALIGN_SLIP_CW'(PAR_DWID);

  align_state_t                  state, state_nxt;
  logic [GBOX_ALIGN_SLIP_CW-1:0] slip_nxt;
  logic [MW-1:0]                 match_cnt, match_nxt;
  logic [LW-1:0]                 miss_cnt, miss_nxt;
  logic [WW-1:0]                 wait_cnt, wait_nxt;
  logic                          word_match;

  // Data side: a word exists only in cycles with rx_dvalid=1; there is no
  // back-pressure. Bitslip side: bitslip_adj is a single-cycle request that
  // the gearbox always accepts; its effect shows up a few valid words later,
  // which the WAIT state absorbs.
  assign word_match = (rx_data == cfg_pattern);

  always_comb begin
    state_nxt = state;
    slip_nxt  = slip_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    wait_nxt  = wait_cnt;
    if (!cfg_en) begin
      state_nxt = IDLE;
      slip_nxt  = '0;
      match_nxt = '0;
      miss_nxt  = '0;
      wait_nxt  = '0;
    end else if (train_start) begin
      state_nxt = CHECK;
      slip_nxt  = '0;
      match_nxt = '0;
      miss_nxt  = '0;
      wait_nxt  = '0;
    end else begin
      case (state)
        CHECK: begin
          if (rx_dvalid) begin
            if (word_match) begin
              if (match_cnt == MATCH_LAST) begin
                state_nxt = LOCKED;
                match_nxt = '0;
                miss_nxt  = '0;
              end else begin
                match_nxt = match_cnt + MW'(1);
              end
            end else begin
              match_nxt = '0;
              // After a full rotation every alignment has been tried.
              state_nxt = (slip_cnt == SLIP_FULL) ? ERROR : SLIP;
            end
          end
        end
        SLIP: begin
          state_nxt = WAIT;
          wait_nxt  = '0;
          if (slip_cnt != '1) slip_nxt = slip_cnt + GBOX_ALIGN_SLIP_CW'(1);
        end
        WAIT: begin
          if (rx_dvalid) begin
            if (wait_cnt == WAIT_LAST) begin
              state_nxt = CHECK;
              wait_nxt  = '0;
              match_nxt = '0;
            end else begin
              wait_nxt = wait_cnt + WW'(1);
            end
          end
        end
        LOCKED: begin
          if (rx_dvalid) begin
            if (word_match) begin
              miss_nxt = '0;
            end else if (miss_cnt == MISS_LAST) begin
              state_nxt = CHECK;
              slip_nxt  = '0;
              miss_nxt  = '0;
              match_nxt = '0;
            end else begin
              miss_nxt = miss_cnt + LW'(1);
            end
          end
        end
        IDLE:    state_nxt = IDLE;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (rx_reset) begin
      state      <= IDLE;
      slip_cnt   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      wait_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      slip_cnt  <= slip_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      wait_cnt  <= wait_nxt;
      if (!cfg_en) begin
        dout <= '0;
      end else if (rx_dvalid) begin
        dout <= rx_data;
      end
      dout_valid <= rx_dvalid & align_lock & cfg_en;
    end
  end

  assign bitslip_adj = (state == SLIP);
  assign align_lock  = (state == LOCKED);
  assign align_error = (state == ERROR);
  assign state_dbg   = state;

endmodule

// File: tb/tb_gbox_rx_word_align.sv
// Bench for gbox_rx_word_align: a rotating gearbox model feeds the aligner,
// scenario tables and randomized offsets are checked against spec arithmetic.
module tb_gbox_rx_word_align;
  import gbox_align_pkg::*;

  localparam int DW = 10;
  localparam int MATCH = 4;
  localparam int LOSS = 4;
  localparam int SWAIT = 4;
  localparam logic [DW-1:0] PAT = GBOX_ALIGN_DEF_PATTERN;
  localparam logic [DW-1:0] BAD = 10'h155;

  // ---------------- clock / reset ----------------
  logic core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic          rx_reset, cfg_en, train_start, rx_dvalid;
  logic [DW-1:0] cfg_pattern, rx_data;
  logic          bitslip_adj, align_lock, align_error, dout_valid;
  logic [3:0]    slip_cnt;
  logic [DW-1:0] dout;
  align_state_t  state_dbg;

  gbox_rx_word_align #(
    .PAR_DWID(DW), .PAR_MATCH_CNT(MATCH), .PAR_LOSS_CNT(LOSS), .PAR_SLIP_WAIT(SWAIT)
  ) dut (
    .core_clk(core_clk), .rx_reset(rx_reset), .cfg_en(cfg_en),
    .cfg_pattern(cfg_pattern), .train_start(train_start),
    .rx_dvalid(rx_dvalid), .rx_data(rx_data),
    .bitslip_adj(bitslip_adj), .align_lock(align_lock), .align_error(align_error),
    .slip_cnt(slip_cnt), .dout(dout), .dout_valid(dout_valid), .state_dbg(state_dbg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rot = 0;
  int gb_q[$];
  bit src_zero = 1'b0;
  bit src_bad = 1'b0;
  int dv_mode = 0;
  bit tog = 1'b0;
  int pulse_cnt, b2b, min_gap, last_pulse, vw_eval, lock_cyc, start_cyc;
  bit prev_slip = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dout_exp = '0;

  typedef struct {
    string name;
    int    off;
    int    dvm;
    int    zero;
    int    exp_pulses;
    int    exp_slip;
    int    exp_lock;
    int    exp_err;
    int    exp_lat;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] w, input int n);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[0], r[DW-1:1]};
    return r;
  endfunction

  // ---------------- driver ----------------
  // One core clock: gearbox model produces the word (rotation by pending
  // slips, 2 valid-word latency), then outputs are sampled 1 ns after the edge.
  task automatic cycle();
    bit v, pre_slip, pre_lock;
    logic [DW-1:0] word, exp_d;
    case (dv_mode)
      0: v = 1'b1;
      1: begin v = ~tog; tog = ~tog; end
      default: v = ($urandom_range(0, 9) < 7);
    endcase
    word = DW'($urandom);
    if (v) begin
      if (gb_q.size() > 0 && gb_q[0] == 0) begin
        void'(gb_q.pop_front());
        rot = (rot + DW - 1) % DW;
      end
      word = src_bad ? BAD : (src_zero ? '0 : rotr(PAT, rot));
      foreach (gb_q[i]) gb_q[i] = gb_q[i] - 1;
    end
    rx_dvalid = v;
    rx_data   = word;
    pre_slip  = bitslip_adj;
    pre_lock  = align_lock;
    if (rx_reset || !cfg_en) exp_d = '0;
    else if (v) exp_d = word;
    else exp_d = last_dout_exp;
    last_dout_exp = exp_d;
    exp_q.push_back(exp_d);
    if (v && !pre_slip && !pre_lock && lock_cyc < 0) vw_eval++;
    @(posedge core_clk);
    #1;
    cyc++;
    chk("dout_pipe", dout, exp_q.pop_front());
    if (bitslip_adj) begin
      pulse_cnt++;
      gb_q.push_back(2);
      if (prev_slip) b2b++;
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    prev_slip = bitslip_adj;
    if (align_lock && lock_cyc < 0) lock_cyc = cyc;
  endtask

  task automatic clr_stats();
    pulse_cnt = 0; b2b = 0; min_gap = 1000; last_pulse = -1;
    vw_eval = 0; lock_cyc = -1; start_cyc = cyc;
  endtask

  task automatic set_src(input int off, input int dvm, input bit zero);
    rot = off; gb_q.delete(); src_zero = zero; src_bad = 1'b0; dv_mode = dvm;
  endtask

  task automatic do_train();
    train_start = 1'b1;
    cycle();
    train_start = 1'b0;
    clr_stats();
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (align_lock !== 1'b1 && align_error !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk("done_within_budget", n < budget, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bitslip"}, bitslip_adj, 0);
    chk({tag, "_lock"}, align_lock, 0);
    chk({tag, "_error"}, align_error, 0);
    chk({tag, "_slip_cnt"}, slip_cnt, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_state"}, state_dbg, IDLE);
  endtask

  task automatic check_locked_data(input string tag);
    dv_mode = 0;
    cycle();
    cycle();
    chk({tag, "_dout"}, dout, PAT);
    chk({tag, "_dout_valid"}, dout_valid, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    int off, n;
    tv[0] = '{"aligned",        0, 0, 0,  0,  0, 1, 0,  4};
    tv[1] = '{"offset3",        3, 0, 0,  3,  3, 1, 0, 22};
    tv[2] = '{"offset2_toggle", 2, 1, 0,  2,  2, 1, 0, -1};
    tv[3] = '{"no_pattern",     0, 0, 1, 10, 10, 0, 1, -1};
    tv[4] = '{"offset9",        9, 0, 0,  9,  9, 1, 0, 58};

    rx_reset = 1'b1; cfg_en = 1'b1; cfg_pattern = PAT; train_start = 1'b0;
    rx_dvalid = 1'b0; rx_data = '0;
    set_src(0, 0, 0);
    clr_stats();
    repeat (3) cycle();
    chk_zero("reset");
    rx_reset = 1'b0;
    repeat (3) cycle();
    chk("idle_no_pulse", pulse_cnt, 0);
    chk("idle_state", state_dbg, IDLE);

    // Table-driven alignment scenarios.
    for (int r = 0; r < 5; r++) begin
      set_src(tv[r].off, tv[r].dvm, tv[r].zero[0]);
      do_train();
      run_to_done(400);
      chk({tv[r].name, "_pulses"}, pulse_cnt, tv[r].exp_pulses);
      chk({tv[r].name, "_slip_cnt"}, slip_cnt, tv[r].exp_slip);
      chk({tv[r].name, "_lock"}, align_lock, tv[r].exp_lock);
      chk({tv[r].name, "_error"}, align_error, tv[r].exp_err);
      chk({tv[r].name, "_back_to_back"}, b2b, 0);
      if (tv[r].exp_pulses > 1) chk({tv[r].name, "_gap_ge5"}, min_gap >= 5, 1);
      if (tv[r].exp_lat >= 0) chk({tv[r].name, "_lock_latency"}, lock_cyc - start_cyc, tv[r].exp_lat);
      if (tv[r].exp_lock != 0) begin
        chk({tv[r].name, "_valid_words"}, vw_eval, tv[r].exp_slip * (1 + SWAIT) + MATCH);
        check_locked_data(tv[r].name);
      end
    end

    // Randomized offsets and valid density against the rotation model.
    for (int it = 0; it < 12; it++) begin
      off = $urandom_range(0, DW - 1);
      set_src(off, 2, 1'b0);
      do_train();
      run_to_done(600);
      chk("rand_pulses", pulse_cnt, off);
      chk("rand_slip_cnt", slip_cnt, off);
      chk("rand_lock", align_lock, 1);
      chk("rand_error", align_error, 0);
      chk("rand_back_to_back", b2b, 0);
      if (off > 1) chk("rand_gap_ge5", min_gap >= 5, 1);
      chk("rand_valid_words", vw_eval, off * (1 + SWAIT) + MATCH);
    end

    // Loss of lock: 3 bad + 1 good holds lock, 4 consecutive bad drops it.
    set_src(0, 0, 1'b0);
    do_train();
    run_to_done(100);
    src_bad = 1'b1; repeat (3) cycle();
    src_bad = 1'b0; cycle();
    src_bad = 1'b1; repeat (3) cycle();
    chk("loss_lock_held", align_lock, 1);
    cycle();
    chk("loss_lock_dropped", align_lock, 0);
    chk("loss_state_check", state_dbg, CHECK);
    chk("loss_slip_cleared", slip_cnt, 0);
    src_bad = 1'b0;
    clr_stats();
    run_to_done(100);
    chk("relock", align_lock, 1);
    chk("relock_latency", lock_cyc - start_cyc, MATCH);
    chk("relock_pulses", pulse_cnt, 0);

    // Error is sticky and cleared by train_start.
    set_src(0, 0, 1'b1);
    do_train();
    run_to_done(400);
    repeat (5) cycle();
    chk("err_sticky", align_error, 1);
    chk("err_no_lock", align_lock, 0);
    chk("err_pulses", pulse_cnt, DW);
    do_train();
    chk("err_cleared", align_error, 0);
    chk("err_slip_cleared", slip_cnt, 0);
    chk("err_restart_state", state_dbg, CHECK);

    // train_start during SLIP: in-flight pulse still rotates the gearbox.
    set_src(3, 0, 1'b0);
    do_train();
    n = 0;
    while (bitslip_adj !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("slip_seen", bitslip_adj, 1);
    do_train();
    chk("slip_restart_cnt", slip_cnt, 0);
    chk("slip_restart_state", state_dbg, CHECK);
    run_to_done(200);
    chk("slip_restart_lock", align_lock, 1);
    chk("slip_restart_pulses", pulse_cnt, 2);
    chk("slip_restart_slip_cnt", slip_cnt, 2);

    // rx_reset during WAIT.
    set_src(3, 0, 1'b0);
    do_train();
    n = 0;
    while (state_dbg !== WAIT && n < 20) begin cycle(); n++; end
    chk("wait_reached", state_dbg, WAIT);
    rx_reset = 1'b1;
    cycle();
    chk_zero("rst_wait");
    rx_reset = 1'b0;
    clr_stats();
    repeat (20) cycle();
    chk("rst_wait_no_pulse", pulse_cnt, 0);
    chk("rst_wait_idle", state_dbg, IDLE);

    // cfg_en low during LOCKED.
    set_src(0, 0, 1'b0);
    do_train();
    run_to_done(100);
    chk("cfg_pre_lock", align_lock, 1);
    cfg_en = 1'b0;
    cycle();
    chk_zero("cfg_off");
    cfg_en = 1'b1;
    clr_stats();
    repeat (20) cycle();
    chk("cfg_off_no_pulse", pulse_cnt, 0);
    chk("cfg_off_idle", state_dbg, IDLE);
    chk("cfg_off_no_lock", align_lock, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
